plot_arbiter: RTL

PLOT_ARBITER -- requirements
Module: plot_arbiter

---
 rtl/plot_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/plot_arbiter.sv
// Four-player plot arbiter with full-screen clear for a VGA adapter.
// Round-robin pixel grants, one registered plot strobe per cycle.
module plot_arbiter #(
    parameter int         SCR_W  = 160,
    parameter int         SCR_H  = 120,
    parameter logic [2:0] P1_COL = 3'b001,
    parameter logic [2:0] P2_COL = 3'b010,
    parameter logic [2:0] P3_COL = 3'b100,
    parameter logic [2:0] P4_COL = 3'b110
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [14:0] p1,
    input  logic [14:0] p2,
    input  logic [14:0] p3,
    input  logic [14:0] p4,
    input  logic        clear_req,
    input  logic [2:0]  clear_colour,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic [3:0]  gnt,
    output logic        clearing,
    output logic        clear_done
);

    typedef enum logic [1:0] {IDLE, SERVE, CLEAR} state_t;

    localparam logic [8:0] W_LIM  = SCR_W[8:0];
    localparam logic [7:0] H_LIM  = SCR_H[7:0];
    localparam logic [7:0] CX_MAX = 8'(SCR_W - 1);
    localparam logic [6:0] CY_MAX = 7'(SCR_H - 1);

    state_t      state, state_n;
    logic [1:0]  ptr, ptr_n;
    logic [7:0]  cx, cx_n;
    logic [6:0]  cy, cy_n;
    logic [2:0]  fill_col, fill_col_n;
    logic        fill_end, fill_end_n;
    logic [7:0]  x_n;
    logic [6:0]  y_n;
    logic [2:0]  colour_n;
    logic        plot_n, clearing_n, clear_done_n;
    logic [3:0]  gnt_n;

    logic [1:0]  win;
    logic        hit;
    logic [14:0] pos;
    logic [2:0]  pcol;
    logic        on_screen;

    // Round-robin search starting one past the last granted player.
    always_comb begin
        logic [1:0] idx;
        win = ptr;
        hit = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr + i[1:0];
            if (!hit && req[idx]) begin
                hit = 1'b1;
                win = idx;
            end
        end
        unique case (win)
            2'd0: begin pos = p1; pcol = P1_COL; end
            2'd1: begin pos = p2; pcol = P2_COL; end
            2'd2: begin pos = p3; pcol = P3_COL; end
            default: begin pos = p4; pcol = P4_COL; end
        endcase
        on_screen = ({1'b0, pos[14:7]} < W_LIM) && ({1'b0, pos[6:0]} < H_LIM);
    end

    // Next-state and next-output logic; outputs default to idle strobes.
    always_comb begin
        state_n      = state;
        ptr_n        = ptr;
        cx_n         = cx;
        cy_n         = cy;
        fill_col_n   = fill_col;
        fill_end_n   = fill_end;
        x_n          = x;
        y_n          = y;
        colour_n     = colour;
        plot_n       = 1'b0;
        gnt_n        = 4'b0000;
        clearing_n   = 1'b0;
        clear_done_n = 1'b0;
        case (state)
            CLEAR: begin
                if (fill_end) begin
                    clear_done_n = 1'b1;
                    fill_end_n   = 1'b0;
                    state_n      = IDLE;
                end else begin
                    x_n        = cx;
                    y_n        = cy;
                    colour_n   = fill_col;
                    plot_n     = 1'b1;
                    clearing_n = 1'b1;
                    if (cx == CX_MAX && cy == CY_MAX) begin
                        fill_end_n = 1'b1;
                    end else if (cx == CX_MAX) begin
                        cx_n = 8'd0;
                        cy_n = cy + 7'd1;
                    end else begin
                        cx_n = cx + 8'd1;
                    end
                end
            end
            default: begin
                if (clear_req) begin
                    state_n    = CLEAR;
                    cx_n       = 8'd0;
                    cy_n       = 7'd0;
                    fill_col_n = clear_colour;
                    fill_end_n = 1'b0;
                end else if (hit) begin
                    gnt_n    = 4'b0001 << win;
                    x_n      = pos[14:7];
                    y_n      = pos[6:0];
                    colour_n = pcol;
                    plot_n   = on_screen;
                    ptr_n    = win;
                    state_n  = SERVE;
                end else begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    // State and registered outputs; reset aborts any fill silently.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= 2'd3;
            cx         <= 8'd0;
            cy         <= 7'd0;
            fill_col   <= 3'd0;
            fill_end   <= 1'b0;
            x          <= 8'd0;
            y          <= 7'd0;
            colour     <= 3'd0;
            plot       <= 1'b0;
            gnt        <= 4'b0000;
            clearing   <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            cx         <= cx_n;
            cy         <= cy_n;
            fill_col   <= fill_col_n;
            fill_end   <= fill_end_n;
            x          <= x_n;
            y          <= y_n;
            colour     <= colour_n;
            plot       <= plot_n;
            gnt        <= gnt_n;
            clearing   <= clearing_n;
            clear_done <= clear_done_n;
        end
    end

endmodule
